// File: rtl/static_sequence_detector_pkg.sv
// static_sequence_detector_pkg: shared state encoding and pattern/alarm constants for the sequence path
package static_sequence_detector_pkg;
  typedef enum logic [1:0] {S_FILL, S_RUN, S_ALARM} state_e;
  localparam logic [7:0] DEFAULT_PATTERN = 8'b10111000;
  localparam int TICK_1S = 100_000_000;
  localparam int BUZZ_CYCLES_DEFAULT = TICK_1S;
endpackage

// File: rtl/static_sequence_detector_alarm_timer.sv
// static_sequence_detector_alarm_timer: loadable down-counter; busy_o stays high load_val_i+1 cycles
module static_sequence_detector_alarm_timer #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         busy_o,
  output logic         done_o
);
  logic         busy_q, busy_d;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    done_o = busy_q && cnt_q == '0;
    busy_d = clr_i ? 1'b0 : load_i ? 1'b1 : done_o ? 1'b0 : busy_q;
    cnt_d  = clr_i ? '0 : load_i ? load_val_i : (busy_q && !done_o) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end
  assign busy_o = busy_q;
endmodule

// File: rtl/static_sequence_detector.sv
// static_sequence_detector: serial pattern detector with detect pulse, wrapping count, LED history and timed buzzer
module static_sequence_detector
  import static_sequence_detector_pkg::*;
#(
  parameter int         PAT_LEN     = 8,
  parameter logic [7:0] PATTERN     = DEFAULT_PATTERN,
  parameter bit         OVERLAP     = 1'b1,
  parameter int         BUZZ_CYCLES = BUZZ_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] led,
  output logic       det_pulse,
  output logic [3:0] det_cnt,
  output logic       buzzer
);
  localparam int         CW   = BUZZ_CYCLES > 1 ? $clog2(BUZZ_CYCLES) : 1;
  localparam logic [3:0] FULL = 4'(PAT_LEN);
  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] bits_seen_q, bits_seen_d, seen_inc;
  logic [3:0] det_cnt_q, det_cnt_d;
  logic       det_pulse_q, det_pulse_d;
  logic       match, tmr_load, tmr_done;
  // bits_seen gates the compare so reset zeros never match an all-zero pattern
  always_comb begin
    shreg_d     = clr ? '0 : bit_valid ? {shreg_q[6:0], bit_in} : shreg_q;
    seen_inc    = bits_seen_q == FULL ? FULL : bits_seen_q + 4'd1;
    match       = bit_valid && !clr && seen_inc == FULL &&
                  shreg_d[PAT_LEN-1:0] == PATTERN[PAT_LEN-1:0];
    bits_seen_d = clr ? '0 : !bit_valid ? bits_seen_q : (match && !OVERLAP) ? '0 : seen_inc;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FILL;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = clr ? S_FILL :
              match ? S_ALARM :
              (state_q == S_ALARM && !tmr_done) ? S_ALARM :
              bits_seen_d == FULL ? S_RUN : S_FILL;
  end
  always_comb begin
    tmr_load    = match;
    det_pulse_d = match;
    det_cnt_d   = clr ? '0 : match ? det_cnt_q + 4'd1 : det_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      bits_seen_q <= '0;
      det_cnt_q   <= '0;
      det_pulse_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bits_seen_q <= bits_seen_d;
      det_cnt_q   <= det_cnt_d;
      det_pulse_q <= det_pulse_d;
    end
  end
  static_sequence_detector_alarm_timer #(.W(CW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr),
    .load_i    (tmr_load),
    .load_val_i(CW'(BUZZ_CYCLES - 1)),
    .busy_o    (buzzer),
    .done_o    (tmr_done)
  );
  assign led       = shreg_q;
  assign det_pulse = det_pulse_q;
  assign det_cnt   = det_cnt_q;
endmodule

// File: tb/tb_static_sequence_detector.sv
// tb_static_sequence_detector: directed checks of match timing, fill guard, overlap, retrigger, clr and reset
module tb_static_sequence_detector;
  import static_sequence_detector_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
  logic [7:0] led_a, led_z, led_o, led_n;
  logic       det_a, det_z, det_o, det_n;
  logic [3:0] cnt_a, cnt_z, cnt_o, cnt_n;
  logic       buz_a, buz_z, buz_o, buz_n;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  static_sequence_detector #(.BUZZ_CYCLES(10)) u_def (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_valid(bit_valid), .bit_in(bit_in),
    .led(led_a), .det_pulse(det_a), .det_cnt(cnt_a), .buzzer(buz_a));
  static_sequence_detector #(.PATTERN(8'h00), .BUZZ_CYCLES(10)) u_zero (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_valid(bit_valid), .bit_in(bit_in),
    .led(led_z), .det_pulse(det_z), .det_cnt(cnt_z), .buzzer(buz_z));
  static_sequence_detector #(.PAT_LEN(4), .PATTERN(8'h0A), .OVERLAP(1'b1), .BUZZ_CYCLES(20)) u_ov (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_valid(bit_valid), .bit_in(bit_in),
    .led(led_o), .det_pulse(det_o), .det_cnt(cnt_o), .buzzer(buz_o));
  static_sequence_detector #(.PAT_LEN(4), .PATTERN(8'h0A), .OVERLAP(1'b0), .BUZZ_CYCLES(20)) u_no (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bit_valid(bit_valid), .bit_in(bit_in),
    .led(led_n), .det_pulse(det_n), .det_cnt(cnt_n), .buzzer(buz_n));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic strobe(input logic b);
    bit_valid = 1'b1; bit_in = b;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    logic [7:0] bits;
    logic [5:0] mask_o, mask_n;
    int pulses, n;
    logic cont;
    do_reset();
    check("rst_led", led_a, 8'h00);
    check("rst_det", det_a, 1'b0);
    check("rst_cnt", cnt_a, 4'd0);
    check("rst_buz", buz_a, 1'b0);
    check("rst_state", 32'(u_def.state_q), 32'(S_FILL));
    // basic match of 1011_1000
    bits = 8'b10111000;
    pulses = 0;
    for (int i = 7; i >= 1; i--) begin
      strobe(bits[i]);
      pulses += int'(det_a);
    end
    check("basic_early", pulses, 0);
    strobe(bits[0]);
    check("basic_det", det_a, 1'b1);
    check("basic_led", led_a, 8'hB8);
    check("basic_cnt", cnt_a, 4'd1);
    check("basic_state", 32'(u_def.state_q), 32'(S_ALARM));
    n = 0;
    while (buz_a && n < 100) begin
      n++;
      @(negedge clk);
      if (n == 1) check("basic_det_1cyc", det_a, 1'b0);
    end
    check("basic_buzz_len", n, 10);
    check("basic_state_run", 32'(u_def.state_q), 32'(S_RUN));
    // fill guard with all-zero pattern
    do_reset();
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      strobe(1'b0);
      pulses += int'(det_z);
    end
    check("zero_no_early", pulses, 0);
    strobe(1'b0);
    check("zero_det", det_z, 1'b1);
    check("zero_cnt", cnt_z, 4'd1);
    // overlap vs non-overlap on 1,0,1,0,1,0
    do_reset();
    mask_o = '0; mask_n = '0;
    for (int i = 0; i < 6; i++) begin
      strobe(i % 2 == 0);
      mask_o[i] = det_o;
      mask_n[i] = det_n;
    end
    check("ov_mask", mask_o, 6'b101000);
    check("ov_cnt", cnt_o, 4'd2);
    check("nov_mask", mask_n, 6'b001000);
    check("nov_cnt", cnt_n, 4'd1);
    // retrigger during alarm
    do_reset();
    strobe(1); strobe(0); strobe(1); strobe(0);
    check("rt_det1", det_o, 1'b1);
    cont = buz_o;
    repeat (3) begin
      @(negedge clk);
      cont &= buz_o;
    end
    strobe(1);
    cont &= buz_o;
    strobe(0);
    cont &= buz_o;
    check("rt_det2", det_o, 1'b1);
    check("rt_cnt", cnt_o, 4'd2);
    check("rt_continuous", cont, 1'b1);
    n = 0;
    while (buz_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rt_buzz_len", n, 20);
    // clr wins over a simultaneous strobe
    do_reset();
    strobe(1); strobe(0); strobe(1); strobe(0); strobe(1);
    check("clr_pre_buz", buz_o, 1'b1);
    clr = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(negedge clk);
    clr = 1'b0; bit_valid = 1'b0;
    check("clr_led", led_o, 8'h00);
    check("clr_cnt", cnt_o, 4'd0);
    check("clr_buz", buz_o, 1'b0);
    check("clr_seen", u_ov.bits_seen_q, 4'd0);
    check("clr_state", 32'(u_ov.state_q), 32'(S_FILL));
    strobe(0); strobe(1); strobe(0);
    check("clr_discard", led_o, 8'h02);
    // asynchronous reset mid-alarm
    do_reset();
    for (int i = 7; i >= 0; i--) strobe(bits[i]);
    @(negedge clk);
    check("ar_buz_pre", buz_a, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("ar_buz_async", buz_a, 1'b0);
    check("ar_led_async", led_a, 8'h00);
    check("ar_cnt_async", cnt_a, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_buz_after", buz_a, 1'b0);
    check("ar_det_after", det_a, 1'b0);
    check("ar_led_after", led_a, 8'h00);
    // 16 overlapping matches wrap the counter
    do_reset();
    pulses = 0;
    for (int i = 0; i < 34; i++) begin
      strobe(i % 2 == 0);
      pulses += int'(det_o);
      if (pulses == 15 && i == 31) check("wrap_cnt15", cnt_o, 4'd15);
    end
    check("wrap_pulses", pulses, 16);
    check("wrap_cnt", cnt_o, 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
